// File: rtl/async_short_to_long_tx.sv
// Source end of a 4-phase req/ack bundled-data crossing.
// Pulse events launch a held req/data pair with a 1-deep backlog slot.
module async_short_to_long_tx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DROP_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              clr_i,
  input  logic              ack_i,
  output logic              req_o,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              ovf_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_REL  = 2'd2;

  localparam logic [DROP_W-1:0] CNT_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

  logic [1:0]             state_q, state_d;
  logic                   req_q, req_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [DATA_W-1:0]      hold_data_q, hold_data_d;
  logic                   hold_v_q, hold_v_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   done_q, done_d;
  logic                   ovf_q, ovf_d;
  logic [DROP_W-1:0]      drop_cnt_q, drop_cnt_d;

  logic ack_s;
  logic ev_busy;
  logic drop;

  assign ack_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], ack_i};
    state_d     = state_q;
    req_d       = req_q;
    data_d      = data_q;
    hold_data_d = hold_data_q;
    hold_v_d    = hold_v_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q;
    drop_cnt_d  = drop_cnt_q;
    ev_busy     = 1'b0;
    drop        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pulse_i) begin
          data_d  = data_i;
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        ev_busy = pulse_i;
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = S_REL;
        end
      end
      S_REL: begin
        if (!ack_s) begin
          done_d = 1'b1;
          if (hold_v_q) begin
            // backlog relaunches; a same-cycle event refills the slot
            data_d  = hold_data_q;
            req_d   = 1'b1;
            state_d = S_REQ;
            if (pulse_i) begin
              hold_data_d = data_i;
            end else begin
              hold_v_d = 1'b0;
            end
          end else if (pulse_i) begin
            data_d  = data_i;
            req_d   = 1'b1;
            state_d = S_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          ev_busy = pulse_i;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase

    if (ev_busy) begin
      if (!hold_v_q) begin
        hold_data_d = data_i;
        hold_v_d    = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end

    if (clr_i) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (clr_i) begin
        drop_cnt_d = CNT_ONE;
      end else if (!(&drop_cnt_q)) begin
        drop_cnt_d = drop_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      data_q      <= '0;
      hold_data_q <= '0;
      hold_v_q    <= 1'b0;
      sync_q      <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      data_q      <= data_d;
      hold_data_q <= hold_data_d;
      hold_v_q    <= hold_v_d;
      sync_q      <= sync_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign req_o      = req_q;
  assign data_o     = data_q;
  assign busy_o     = (state_q != S_IDLE) || hold_v_q;
  assign done_o     = done_q;
  assign ovf_o      = ovf_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_async_short_to_long_tx.sv
// Directed and scoreboarded bench for async_short_to_long_tx.
// Outputs are sampled 1ns after each rising edge; inputs change there too.
module tb_async_short_to_long_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pulse_i = 1'b0;
  logic [7:0] data_i = '0;
  logic       clr_i = 1'b0;
  logic       ack_i = 1'b0;
  logic       req_o;
  logic [7:0] data_o;
  logic       busy_o;
  logic       done_o;
  logic       ovf_o;
  logic [3:0] drop_cnt_o;

  int checks = 0;
  int failures = 0;

  async_short_to_long_tx #(
    .DATA_W(8), .SYNC_STAGES(2), .DROP_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pulse_i(pulse_i), .data_i(data_i),
    .clr_i(clr_i), .ack_i(ack_i),
    .req_o(req_o), .data_o(data_o),
    .busy_o(busy_o), .done_o(done_o),
    .ovf_o(ovf_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic handshake(input string tag);
    ack_i = 1'b1;
    ticks(3);
    chk({tag, "_req_fall"}, 32'(req_o), 32'd0);
    ack_i = 1'b0;
    ticks(3);
    chk({tag, "_done"}, 32'(done_o), 32'd1);
  endtask

  // random-phase scoreboard state
  logic [7:0] exp_q[$];
  int sent, delivered, drops_seen;
  int dst_st, dst_dly;
  logic prev_req;
  logic [7:0] prev_data;
  logic [3:0] prev_cnt;
  logic clr_cyc;

  initial begin
    ticks(2);
    rst_n = 1'b1;
    ticks(1);
    chk("rst_req", 32'(req_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_ovf", 32'(ovf_o), 32'd0);
    chk("rst_cnt", 32'(drop_cnt_o), 32'd0);

    // single launch: pulse at edge 0
    pulse_i = 1'b1; data_i = 8'h5A;
    ticks(1);
    pulse_i = 1'b0;
    ticks(1);
    chk("t1_req_up", 32'(req_o), 32'd1);
    chk("t1_data", 32'(data_o), 32'h5A);
    ticks(3);
    ack_i = 1'b1;
    ticks(2);
    chk("t1_req_e6", 32'(req_o), 32'd1);
    ticks(1);
    chk("t1_req_e7", 32'(req_o), 32'd0);
    ticks(2);
    ack_i = 1'b0;
    ticks(2);
    chk("t1_done_e11", 32'(done_o), 32'd0);
    chk("t1_busy_e11", 32'(busy_o), 32'd1);
    ticks(1);
    chk("t1_done_e12", 32'(done_o), 32'd1);
    chk("t1_busy_e12", 32'(busy_o), 32'd0);
    chk("t1_data_e12", 32'(data_o), 32'h5A);
    ticks(1);
    chk("t1_done_e13", 32'(done_o), 32'd0);

    // hold slot
    pulse_i = 1'b1; data_i = 8'h11;
    ticks(1);
    data_i = 8'h22;
    ticks(1);
    pulse_i = 1'b0;
    chk("t2_hold_v", 32'(dut.hold_v_q), 32'd1);
    chk("t2_busy", 32'(busy_o), 32'd1);
    chk("t2_data", 32'(data_o), 32'h11);
    handshake("t2_a");
    chk("t2_relaunch", 32'(req_o), 32'd1);
    chk("t2_data2", 32'(data_o), 32'h22);
    chk("t2_busy2", 32'(busy_o), 32'd1);
    chk("t2_hold_v2", 32'(dut.hold_v_q), 32'd0);
    handshake("t2_b");
    chk("t2_idle", 32'(busy_o), 32'd0);

    // drop and saturation
    pulse_i = 1'b1; data_i = 8'h01;
    ticks(1);
    data_i = 8'h02;
    ticks(1);
    data_i = 8'h03;
    ticks(1);
    pulse_i = 1'b0;
    chk("t3_ovf", 32'(ovf_o), 32'd1);
    chk("t3_cnt", 32'(drop_cnt_o), 32'd1);
    chk("t3_data", 32'(data_o), 32'h01);
    chk("t3_hold", 32'(dut.hold_data_q), 32'h02);
    for (int i = 0; i < 20; i++) begin
      pulse_i = 1'b1; data_i = 8'(8'h40 + i);
      ticks(1);
    end
    pulse_i = 1'b0;
    chk("t3_sat", 32'(drop_cnt_o), 32'd15);
    chk("t3_data_sat", 32'(data_o), 32'h01);
    chk("t3_hold_sat", 32'(dut.hold_data_q), 32'h02);
    clr_i = 1'b1;
    ticks(1);
    clr_i = 1'b0;
    chk("t3_clr_ovf", 32'(ovf_o), 32'd0);
    chk("t3_clr_cnt", 32'(drop_cnt_o), 32'd0);

    // clr coinciding with a drop
    clr_i = 1'b1; pulse_i = 1'b1; data_i = 8'h99;
    ticks(1);
    clr_i = 1'b0; pulse_i = 1'b0;
    chk("t4_clr_drop_ovf", 32'(ovf_o), 32'd1);
    chk("t4_clr_drop_cnt", 32'(drop_cnt_o), 32'd1);
    clr_i = 1'b1;
    ticks(1);
    clr_i = 1'b0;

    // completion with full slot and a new event
    ack_i = 1'b1;
    ticks(3);
    chk("t4_req_fall", 32'(req_o), 32'd0);
    ack_i = 1'b0;
    ticks(2);
    pulse_i = 1'b1; data_i = 8'h77;
    ticks(1);
    pulse_i = 1'b0;
    chk("t4_req", 32'(req_o), 32'd1);
    chk("t4_data", 32'(data_o), 32'h02);
    chk("t4_hold", 32'(dut.hold_data_q), 32'h77);
    chk("t4_hold_v", 32'(dut.hold_v_q), 32'd1);
    chk("t4_done", 32'(done_o), 32'd1);
    chk("t4_ovf", 32'(ovf_o), 32'd0);

    // reset mid-REQ
    rst_n = 1'b0;
    ticks(1);
    rst_n = 1'b1;
    chk("t5_req", 32'(req_o), 32'd0);
    chk("t5_data", 32'(data_o), 32'd0);
    chk("t5_busy", 32'(busy_o), 32'd0);
    chk("t5_hold_v", 32'(dut.hold_v_q), 32'd0);
    chk("t5_done", 32'(done_o), 32'd0);
    ack_i = 1'b1;
    ticks(4);
    chk("t5_ack_ign_req", 32'(req_o), 32'd0);
    chk("t5_ack_ign_busy", 32'(busy_o), 32'd0);
    ack_i = 1'b0;
    ticks(3);

    // random traffic with a scoreboard
    sent = 0; delivered = 0; drops_seen = 0;
    dst_st = 0; dst_dly = 0;
    prev_req = req_o; prev_data = data_o; prev_cnt = drop_cnt_o;
    clr_cyc = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (!clr_cyc && drop_cnt_o != prev_cnt) begin
        chk("t6_drop_full", 32'(exp_q.size() >= 2), 32'd1);
        drops_seen += int'(drop_cnt_o) - int'(prev_cnt);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
      end
      if (req_o && !prev_req) begin
        if (exp_q.size() > 0) begin
          chk("t6_order", 32'(data_o), 32'(exp_q.pop_front()));
        end else begin
          chk("t6_spurious", 32'd1, 32'd0);
        end
        delivered++;
      end else if (req_o && prev_req) begin
        chk("t6_stable", 32'(data_o), 32'(prev_data));
      end
      prev_req = req_o; prev_data = data_o; prev_cnt = drop_cnt_o;

      case (dst_st)
        0: if (req_o) begin dst_dly = $urandom_range(0, 10); dst_st = 1; end
        1: if (dst_dly == 0) begin ack_i = 1'b1; dst_st = 2; end
           else dst_dly--;
        2: if (!req_o) begin dst_dly = $urandom_range(0, 10); dst_st = 3; end
        3: if (dst_dly == 0) begin ack_i = 1'b0; dst_st = 0; end
           else dst_dly--;
        default: dst_st = 0;
      endcase

      clr_cyc = (drop_cnt_o >= 4'd8);
      clr_i = clr_cyc;
      pulse_i = 1'b0;
      if (!clr_cyc && cyc < 1200 && $urandom_range(0, 5) == 0) begin
        pulse_i = 1'b1;
        data_i = 8'($urandom_range(0, 255));
        exp_q.push_back(data_i);
        sent++;
      end
      ticks(1);
      if (clr_cyc) prev_cnt = drop_cnt_o;
    end
    clr_i = 1'b0;
    pulse_i = 1'b0;
    chk("t6_drained", 32'(exp_q.size()), 32'd0);
    chk("t6_accounting", 32'(delivered + drops_seen), 32'(sent));
    chk("t6_idle", 32'(busy_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
